inert_burst_rdr: RTL and testbench

//  Parametrised sensor-read sequencer driving an external SPI_mnrch (wrt/done/cmd/rd_data).

---
 rtl/inert_burst_rdr_if.sv | 11 +
 rtl/inert_burst_rdr.sv | 193 +++++++++++++++++++
 tb/tb_inert_burst_rdr.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/inert_burst_rdr_if.sv
// SPI transaction handshake between the burst reader (master) and the SPI_mnrch engine (slave).
// Each wrt pulse starts one 16-bit transaction; done pulses when it completes, and rd_data[7:0] then holds the byte read.
interface inert_burst_rdr_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inert_burst_rdr.sv
// Inertial sensor read sequencer: power-up wait, config writes, then an INT-triggered burst read
// of NUM_CH little-endian signed 16-bit channels, published atomically with a one-clock vld.
module inert_burst_rdr #(
  parameter int unsigned                NUM_CH    = 5,
  parameter logic [6:0]                 BASE_ADDR = 7'h22,
  parameter int unsigned                NUM_INIT  = 4,
  parameter logic [16*NUM_INIT-1:0]     INIT_CMDS = {16'h1460, 16'h1162, 16'h1062, 16'h0D02},
  parameter int unsigned                PWRUP_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     int_i,
  inert_burst_rdr_if.master        spi,
  output logic [16*NUM_CH-1:0]     smpl_o,
  output logic                     vld_o,
  output logic                     ovr_o,
  output logic                     init_done_o,
  output logic                     busy_o
);

  localparam logic [7:0] NUM_INIT_B = 8'(NUM_INIT);
  localparam logic [7:0] LAST_B     = 8'(2 * NUM_CH - 1);

  typedef enum logic [1:0] {S_PWRUP, S_INIT, S_IDLE, S_READ} state_t;

  state_t                state_q, state_d;
  logic [PWRUP_W-1:0]    timer_q, timer_d;
  logic [7:0]            idx_q, idx_d;
  logic                  wrt_q, wrt_d;
  logic [15:0]           cmd_q, cmd_d;
  logic [16*NUM_CH-1:0]  shadow_q, shadow_d;
  logic [16*NUM_CH-1:0]  smpl_q, smpl_d;
  logic                  vld_q, vld_d;
  logic                  ovr_q, ovr_d;
  logic                  ovr_flag_q, ovr_flag_d;
  logic                  init_done_q, init_done_d;
  logic                  busy_q, busy_d;
  logic                  int_meta_q, int_s_q, int_prev_q;
  logic                  int_rise_s;
  logic                  unused_rd_hi_s;

  function automatic logic [15:0] init_word(input int i);
    return INIT_CMDS[16*i +: 16];
  endfunction

  // Read command for byte offset offs from BASE_ADDR; the 7-bit address wraps modulo 128.
  function automatic logic [15:0] rd_cmd(input logic [7:0] offs);
    logic [6:0] addr;
    addr = BASE_ADDR + offs[6:0];
    return {1'b1, addr, 8'h00};
  endfunction

  assign int_rise_s     = int_s_q & ~int_prev_q;
  assign unused_rd_hi_s = ^spi.rd_data[15:8];

  // Two-flop synchroniser for INT plus a prior-value flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta_q <= 1'b0;
      int_s_q    <= 1'b0;
      int_prev_q <= 1'b0;
    end else begin
      int_meta_q <= int_i;
      int_s_q    <= int_meta_q;
      int_prev_q <= int_s_q;
    end
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    shadow_d    = shadow_q;
    smpl_d      = smpl_q;
    vld_d       = 1'b0;
    ovr_d       = 1'b0;
    init_done_d = init_done_q;

    // An INT edge during the burst, or in the cycle its result is published, marks the next result stale.
    if (int_rise_s && ((state_q == S_READ) || vld_q)) begin
      ovr_flag_d = 1'b1;
    end else begin
      ovr_flag_d = ovr_flag_q;
    end

    case (state_q)
      S_PWRUP: begin
        if (timer_q == {PWRUP_W{1'b1}}) begin
          wrt_d   = 1'b1;
          cmd_d   = init_word(0);
          idx_d   = 8'd1;
          state_d = S_INIT;
        end else begin
          timer_d = timer_q + {{(PWRUP_W-1){1'b0}}, 1'b1};
        end
      end
      S_INIT: begin
        if (spi.done) begin
          if (idx_q < NUM_INIT_B) begin
            wrt_d = 1'b1;
            cmd_d = init_word(int'(idx_q));
            idx_d = idx_q + 8'd1;
          end else begin
            init_done_d = 1'b1;
            idx_d       = 8'd0;
            state_d     = S_IDLE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_IDLE: begin
        if (int_s_q) begin
          wrt_d   = 1'b1;
          cmd_d   = rd_cmd(8'd0);
          idx_d   = 8'd0;
          state_d = S_READ;
        end else begin
          idx_d = idx_q;
        end
      end
      S_READ: begin
        if (spi.done) begin
          shadow_d[{idx_q, 3'b000} +: 8] = spi.rd_data[7:0];
          if (idx_q < LAST_B) begin
            wrt_d = 1'b1;
            cmd_d = rd_cmd(idx_q + 8'd1);
            idx_d = idx_q + 8'd1;
          end else begin
            smpl_d     = shadow_d;
            vld_d      = 1'b1;
            ovr_d      = ovr_flag_d;
            ovr_flag_d = 1'b0;
            idx_d      = 8'd0;
            state_d    = S_IDLE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = S_PWRUP;
        timer_d = {PWRUP_W{1'b0}};
        idx_d   = 8'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PWRUP;
      timer_q     <= {PWRUP_W{1'b0}};
      idx_q       <= 8'd0;
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      shadow_q    <= '0;
      smpl_q      <= '0;
      vld_q       <= 1'b0;
      ovr_q       <= 1'b0;
      ovr_flag_q  <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      shadow_q    <= shadow_d;
      smpl_q      <= smpl_d;
      vld_q       <= vld_d;
      ovr_q       <= ovr_d;
      ovr_flag_q  <= ovr_flag_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  assign spi.wrt     = wrt_q;
  assign spi.cmd     = cmd_q;
  assign smpl_o      = smpl_q;
  assign vld_o       = vld_q;
  assign ovr_o       = ovr_q;
  assign init_done_o = init_done_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_inert_burst_rdr.sv
// Directed bench for inert_burst_rdr: a 5-channel instance at 7'h22 and a 2-channel instance whose
// addresses wrap past 7'h7F; both use a short power-up timer. SPI completions are driven from vector tables.
module tb_inert_burst_rdr;
  localparam int LAT = 3;

  typedef struct {
    logic [15:0] exp_cmd;
    logic [7:0]  rd_byte;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, int_r, done_r, sel;
  logic [15:0] rd_r;
  logic [79:0] smpl_a;
  logic [31:0] smpl_b;
  logic        vld_a, ovr_a, idone_a, busy_a;
  logic        vld_b, ovr_b, idone_b, busy_b;

  inert_burst_rdr_if ifa ();
  inert_burst_rdr_if ifb ();

  assign ifa.done    = done_r & ~sel;
  assign ifa.rd_data = rd_r;
  assign ifb.done    = done_r & sel;
  assign ifb.rd_data = rd_r;

  inert_burst_rdr #(.NUM_CH(5), .BASE_ADDR(7'h22), .NUM_INIT(4),
                    .INIT_CMDS(64'h1460_1162_1062_0D02), .PWRUP_W(4)) u_a (
    .clk(clk), .rst(rst_a), .int_i(int_r & ~sel), .spi(ifa), .smpl_o(smpl_a),
    .vld_o(vld_a), .ovr_o(ovr_a), .init_done_o(idone_a), .busy_o(busy_a));

  inert_burst_rdr #(.NUM_CH(2), .BASE_ADDR(7'h7F), .NUM_INIT(4),
                    .INIT_CMDS(64'h1460_1162_1062_0D02), .PWRUP_W(4)) u_b (
    .clk(clk), .rst(rst_b), .int_i(int_r & sel), .spi(ifb), .smpl_o(smpl_b),
    .vld_o(vld_b), .ovr_o(ovr_b), .init_done_o(idone_b), .busy_o(busy_b));

  logic         m_wrt, m_vld, m_ovr, m_idone, m_busy;
  logic [15:0]  m_cmd;
  logic [127:0] m_smpl;
  assign m_wrt   = sel ? ifb.wrt : ifa.wrt;
  assign m_cmd   = sel ? ifb.cmd : ifa.cmd;
  assign m_vld   = sel ? vld_b : vld_a;
  assign m_ovr   = sel ? ovr_b : ovr_a;
  assign m_idone = sel ? idone_b : idone_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_smpl  = sel ? {96'd0, smpl_b} : {48'd0, smpl_a};

  int n_chk  = 0;
  int n_pass = 0;

  vec_t        vec [24];
  logic [15:0] init_cmd [4];
  logic [127:0] s1, s2, sw;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic wait_wrt(input int bound);
    int k;
    k = 0;
    while (m_wrt !== 1'b1 && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wrt arrives", {127'd0, m_wrt}, 128'd1);
  endtask

  // Power-up length check followed by the four config writes, each answered with a done.
  task automatic do_init(input bit idle_done);
    int k;
    k = -1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (m_wrt === 1'b1) begin
        k = e;
        break;
      end
    end
    chk("pwrup length", k, 15);
    chk("init cmd 0", m_cmd, init_cmd[0]);
    chk("busy in init", m_busy, 1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("init wrt pulse", m_wrt, 0);
      repeat (LAT - 1) @(posedge clk);
      #1;
      done_r = 1'b1;
      @(posedge clk); #1;
      done_r = 1'b0;
      if (i < 4) begin
        chk("init wrt", m_wrt, 1);
        chk("init cmd", m_cmd, init_cmd[i]);
        chk("init_done low", m_idone, 0);
      end else begin
        chk("init_done high", m_idone, 1);
        chk("no wrt after init", m_wrt, 0);
        chk("busy idle", m_busy, 0);
      end
    end
    if (idle_done) begin
      done_r = 1'b1;
      @(posedge clk); #1;
      done_r = 1'b0;
      chk("idle done ignored", m_wrt, 0);
      chk("cmd holds", m_cmd, init_cmd[3]);
    end
  endtask

  // One full burst driven from vec[first..first+n-1]; optional INT low/high toggle after done #toggle_at.
  task automatic run_burst(input int first, input int n, input logic [127:0] prev,
                           input logic [127:0] exp, input logic exp_ovr, input int toggle_at);
    wait_wrt(12);
    for (int i = 0; i < n; i++) begin
      chk("rd cmd", m_cmd, vec[first + i].exp_cmd);
      @(posedge clk); #1;
      chk("rd wrt pulse", m_wrt, 0);
      repeat (LAT - 1) @(posedge clk);
      #1;
      if (i == n - 1) chk("smpl holds old", m_smpl, prev);
      done_r = 1'b1;
      rd_r   = {8'hA5, vec[first + i].rd_byte};
      @(posedge clk); #1;
      done_r = 1'b0;
      if (toggle_at > 0 && i + 1 == toggle_at) int_r = 1'b0;
      if (toggle_at > 0 && i == toggle_at) int_r = 1'b1;
      if (i < n - 1) begin
        chk("rd next wrt", m_wrt, 1);
        chk("no early vld", m_vld, 0);
      end else begin
        chk("vld after last done", m_vld, 1);
        chk("smpl", m_smpl, exp);
        chk("ovr", m_ovr, exp_ovr);
        chk("no wrt on last", m_wrt, 0);
      end
    end
    @(posedge clk); #1;
    chk("vld pulse", m_vld, 0);
    chk("ovr cleared", m_ovr, 0);
  endtask

  initial begin
    init_cmd[0] = 16'h0D02; init_cmd[1] = 16'h1062; init_cmd[2] = 16'h1162; init_cmd[3] = 16'h1460;
    vec[0]  = '{16'hA200, 8'h22}; vec[1]  = '{16'hA300, 8'h23}; vec[2]  = '{16'hA400, 8'h24};
    vec[3]  = '{16'hA500, 8'h25}; vec[4]  = '{16'hA600, 8'h26}; vec[5]  = '{16'hA700, 8'h27};
    vec[6]  = '{16'hA800, 8'h28}; vec[7]  = '{16'hA900, 8'h29}; vec[8]  = '{16'hAA00, 8'h2A};
    vec[9]  = '{16'hAB00, 8'h2B};
    vec[10] = '{16'hA200, 8'h80}; vec[11] = '{16'hA300, 8'hFF}; vec[12] = '{16'hA400, 8'h01};
    vec[13] = '{16'hA500, 8'h00}; vec[14] = '{16'hA600, 8'h34}; vec[15] = '{16'hA700, 8'h12};
    vec[16] = '{16'hA800, 8'hCD}; vec[17] = '{16'hA900, 8'hAB}; vec[18] = '{16'hAA00, 8'h00};
    vec[19] = '{16'hAB00, 8'h80};
    vec[20] = '{16'hFF00, 8'h7F}; vec[21] = '{16'h8000, 8'h00}; vec[22] = '{16'h8100, 8'h01};
    vec[23] = '{16'h8200, 8'h02};
    s1 = {48'd0, 16'h2B2A, 16'h2928, 16'h2726, 16'h2524, 16'h2322};
    s2 = {48'd0, 16'h8000, 16'hABCD, 16'h1234, 16'h0001, 16'hFF80};
    sw = {96'd0, 16'h0201, 16'h007F};

    rst_a = 1'b1; rst_b = 1'b1; int_r = 1'b0; done_r = 1'b0; rd_r = 16'h0000; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset wrt", m_wrt, 0);
    chk("reset cmd", m_cmd, 0);
    chk("reset vld", m_vld, 0);
    chk("reset ovr", m_ovr, 0);
    chk("reset init_done", m_idone, 0);
    chk("reset busy", m_busy, 1);
    chk("reset smpl", m_smpl, 0);
    rst_a = 1'b0;
    do_init(1'b1);

    // First burst from a fresh INT edge, then back-to-back bursts while INT stays high.
    int_r = 1'b1;
    run_burst(0, 10, 128'd0, s1, 1'b0, 0);
    chk("back-to-back wrt", m_wrt, 1);
    run_burst(10, 10, s1, s2, 1'b0, 0);
    chk("back-to-back wrt 2", m_wrt, 1);
    run_burst(0, 10, s2, s1, 1'b1, 4);
    chk("back-to-back wrt 3", m_wrt, 1);
    run_burst(10, 10, s1, s2, 1'b0, 0);
    chk("back-to-back wrt 4", m_wrt, 1);

    // Reset after the sixth completion of a burst.
    for (int i = 0; i < 6; i++) begin
      chk("pre-reset cmd", m_cmd, vec[i].exp_cmd);
      repeat (LAT) @(posedge clk);
      #1;
      done_r = 1'b1;
      rd_r   = {8'h00, vec[i].rd_byte};
      @(posedge clk); #1;
      done_r = 1'b0;
      chk("pre-reset wrt", m_wrt, 1);
    end
    rst_a = 1'b1;
    @(posedge clk); #1;
    chk("mid reset wrt", m_wrt, 0);
    chk("mid reset cmd", m_cmd, 0);
    chk("mid reset vld", m_vld, 0);
    chk("mid reset busy", m_busy, 1);
    chk("mid reset init_done", m_idone, 0);
    chk("mid reset smpl", m_smpl, 0);
    rst_a = 1'b0;
    do_init(1'b0);
    run_burst(0, 10, 128'd0, s1, 1'b0, 0);
    int_r = 1'b0;

    // Two-channel instance with address wrap past 7'h7F.
    sel = 1'b1;
    #1;
    chk("b reset busy", m_busy, 1);
    chk("b reset smpl", m_smpl, 0);
    rst_b = 1'b0;
    do_init(1'b0);
    int_r = 1'b1;
    run_burst(20, 4, 128'd0, sw, 1'b0, 0);
    int_r = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
